// File: rtl/dtc_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module   : dtc_cmd_tx
// Purpose  : DTC link command/trigger serializer. Pended L0/L1 triggers win
//            over host commands at frame boundaries. Optional parity bit is
//            compiled in with DTC_CMD_TX_PARITY_EN.
// Revision : 1.0
// ============================================================================
module dtc_cmd_tx #(
    parameter int GUARD_BITS = 2
) (
    input  logic        dtc_clk,
    input  logic        rst_n,
    input  logic        trig_l0_req,
    input  logic        trig_l1_req,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_code,
    input  logic [31:0] cmd_address,
    input  logic [31:0] cmd_data,
    output logic        dtc_trig,
    output logic        busy,
    output logic        trig_drop,
    output logic        cmd_err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_CODE  = 3'd2,
        ST_ADDR  = 3'd3,
        ST_DATA  = 3'd4,
        ST_PAR   = 3'd5,
        ST_GUARD = 3'd6
    } state_t;

    localparam logic [3:0] C_CODE_L0    = 4'h1;
    localparam logic [3:0] C_CODE_L1    = 4'h2;
    localparam logic [3:0] C_CODE_WRITE = 4'h9;
    localparam logic [3:0] C_CODE_READ  = 4'hA;
    localparam logic [5:0] C_GUARD_LAST = 6'(GUARD_BITS - 1);
`ifdef DTC_CMD_TX_PARITY_EN
    localparam state_t     C_TAIL_ST    = ST_PAR;
`else
    localparam state_t     C_TAIL_ST    = ST_GUARD;
`endif

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [3:0]  code_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        l0_pend_q;
    logic        l1_pend_q;
    logic        trig_q;
    logic        busy_q;
    logic        drop_q;
    logic        err_q;
`ifdef DTC_CMD_TX_PARITY_EN
    logic        par_q;
`endif

    logic arb;
    logic hs;
    logic legal;
    logic sel_l0;
    logic sel_l1;
    logic sel_cmd;
    logic l0_pend_d;
    logic l1_pend_d;
    logic drop_d;
    logic bit_d;

    assign cmd_ready = (state_q == ST_IDLE) && !l0_pend_q && !l1_pend_q;
    assign dtc_trig  = trig_q;
    assign busy      = busy_q;
    assign trig_drop = drop_q;
    assign cmd_err   = err_q;

    // Arbitration also runs on the last guard bit so pended triggers chain
    // onto the previous frame with no idle cycle in between.
    always_comb begin
        hs        = cmd_valid && cmd_ready;
        legal     = (cmd_code >= 4'h3) && (cmd_code <= 4'hA);
        arb       = (state_q == ST_IDLE) || ((state_q == ST_GUARD) && (cnt_q == 6'd0));
        sel_l0    = arb && (l0_pend_q || (!l1_pend_q && !hs && trig_l0_req));
        sel_l1    = arb && !sel_l0 && (l1_pend_q || (!hs && trig_l1_req));
        sel_cmd   = hs && legal;
        l0_pend_d = sel_l0 ? (l0_pend_q && trig_l0_req) : (l0_pend_q || trig_l0_req);
        l1_pend_d = sel_l1 ? (l1_pend_q && trig_l1_req) : (l1_pend_q || trig_l1_req);
        drop_d    = (trig_l0_req && l0_pend_q && !sel_l0) ||
                    (trig_l1_req && l1_pend_q && !sel_l1);
    end

    always_comb begin
        bit_d = 1'b0;
        case (state_q)
            ST_START: bit_d = 1'b1;
            ST_CODE:  bit_d = code_q[cnt_q[1:0]];
            ST_ADDR:  bit_d = addr_q[cnt_q[4:0]];
            ST_DATA:  bit_d = data_q[cnt_q[4:0]];
`ifdef DTC_CMD_TX_PARITY_EN
            ST_PAR:   bit_d = par_q;
`endif
            default:  bit_d = 1'b0;
        endcase
    end

    // state_q names the field driven at the next edge; line and busy follow it
    always_ff @(posedge dtc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 6'd0;
            code_q    <= 4'h0;
            addr_q    <= 32'h0;
            data_q    <= 32'h0;
            l0_pend_q <= 1'b0;
            l1_pend_q <= 1'b0;
            trig_q    <= 1'b0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef DTC_CMD_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            trig_q    <= bit_d;
            busy_q    <= (state_q != ST_IDLE);
            drop_q    <= drop_d;
            err_q     <= hs && !legal;
            l0_pend_q <= l0_pend_d;
            l1_pend_q <= l1_pend_d;
`ifdef DTC_CMD_TX_PARITY_EN
            if (state_q == ST_START) begin
                par_q <= 1'b0;
            end else if ((state_q == ST_CODE) || (state_q == ST_ADDR) || (state_q == ST_DATA)) begin
                par_q <= par_q ^ bit_d;
            end
`endif
            case (state_q)
                ST_IDLE, ST_GUARD: begin
                    if ((state_q == ST_GUARD) && (cnt_q != 6'd0)) begin
                        cnt_q <= cnt_q - 6'd1;
                    end else if (sel_l0) begin
                        state_q <= ST_START;
                        code_q  <= C_CODE_L0;
                    end else if (sel_l1) begin
                        state_q <= ST_START;
                        code_q  <= C_CODE_L1;
                    end else if (sel_cmd) begin
                        state_q <= ST_START;
                        code_q  <= cmd_code;
                        addr_q  <= cmd_address;
                        data_q  <= cmd_data;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_START: begin
                    state_q <= ST_CODE;
                    cnt_q   <= 6'd3;
                end
                ST_CODE: begin
                    if (cnt_q != 6'd0) begin
                        cnt_q <= cnt_q - 6'd1;
                    end else if ((code_q == C_CODE_READ) || (code_q == C_CODE_WRITE)) begin
                        state_q <= ST_ADDR;
                        cnt_q   <= 6'd31;
                    end else begin
                        state_q <= C_TAIL_ST;
                        cnt_q   <= C_GUARD_LAST;
                    end
                end
                ST_ADDR: begin
                    if (cnt_q != 6'd0) begin
                        cnt_q <= cnt_q - 6'd1;
                    end else if (code_q == C_CODE_WRITE) begin
                        state_q <= ST_DATA;
                        cnt_q   <= 6'd31;
                    end else begin
                        state_q <= C_TAIL_ST;
                        cnt_q   <= C_GUARD_LAST;
                    end
                end
                ST_DATA: begin
                    if (cnt_q != 6'd0) begin
                        cnt_q <= cnt_q - 6'd1;
                    end else begin
                        state_q <= C_TAIL_ST;
                        cnt_q   <= C_GUARD_LAST;
                    end
                end
                ST_PAR: begin
                    state_q <= ST_GUARD;
                    cnt_q   <= C_GUARD_LAST;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 6'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dtc_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_dtc_cmd_tx
// Purpose  : Scoreboard bench for dtc_cmd_tx; expected line bits are queued
//            as stimulus is driven and popped while busy is high.
// Revision : 1.0
// ============================================================================
module tb_dtc_cmd_tx;

    localparam int G = 2;
`ifdef DTC_CMD_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic        dtc_clk     = 1'b0;
    logic        rst_n       = 1'b0;
    logic        trig_l0_req = 1'b0;
    logic        trig_l1_req = 1'b0;
    logic        cmd_valid   = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_code    = 4'h0;
    logic [31:0] cmd_address = 32'h0;
    logic [31:0] cmd_data    = 32'h0;
    logic        dtc_trig;
    logic        busy;
    logic        trig_drop;
    logic        cmd_err;

    int checks   = 0;
    int errors   = 0;
    int drop_cnt = 0;
    int err_cnt  = 0;
    bit exp_q[$];

    dtc_cmd_tx #(.GUARD_BITS(G)) dut (
        .dtc_clk     (dtc_clk),
        .rst_n       (rst_n),
        .trig_l0_req (trig_l0_req),
        .trig_l1_req (trig_l1_req),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_code    (cmd_code),
        .cmd_address (cmd_address),
        .cmd_data    (cmd_data),
        .dtc_trig    (dtc_trig),
        .busy        (busy),
        .trig_drop   (trig_drop),
        .cmd_err     (cmd_err)
    );

    always #5 dtc_clk = ~dtc_clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Frame model: start, code, payload (MSB first), optional even parity, guard zeros
    function automatic void push_frame(input logic [3:0] code, input logic [31:0] addr,
                                       input logic [31:0] data);
        logic [63:0] payload;
        int          n;
        logic        p;
        n       = (code == 4'h9) ? 64 : ((code == 4'hA) ? 32 : 0);
        payload = (code == 4'h9) ? {addr, data} : {addr, 32'h0};
        p       = ^code;
        exp_q.push_back(1'b1);
        for (int i = 3; i >= 0; i--) exp_q.push_back(code[i]);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(payload[63-i]);
            p = p ^ payload[63-i];
        end
        if (P == 1) exp_q.push_back(p);
        for (int i = 0; i < G; i++) exp_q.push_back(1'b0);
    endfunction

    always @(negedge dtc_clk) begin
        bit b;
        if (rst_n) begin
            if (trig_drop) drop_cnt++;
            if (cmd_err) err_cnt++;
            if (busy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_busy", 64'(busy), 64'd0);
                end else begin
                    b = exp_q.pop_front();
                    chk("line_bit", 64'(dtc_trig), 64'(b));
                end
            end else begin
                chk("idle_line", 64'(dtc_trig), 64'd0);
            end
        end
    end

    // Returns at the negedge just after the handshake edge
    task automatic send_cmd(input logic [3:0] code, input logic [31:0] addr, input logic [31:0] data);
        int n = 0;
        @(negedge dtc_clk);
        cmd_valid   = 1'b1;
        cmd_code    = code;
        cmd_address = addr;
        cmd_data    = data;
        while (!cmd_ready && n < 400) begin
            @(negedge dtc_clk);
            n++;
        end
        if (!cmd_ready) chk("ready_timeout", 64'(cmd_ready), 64'd1);
        @(negedge dtc_clk);
        cmd_valid   = 1'b0;
        cmd_code    = ~code;
        cmd_address = ~addr;
        cmd_data    = ~data;
    endtask

    task automatic pulse_trig(input logic l0, input logic l1);
        @(negedge dtc_clk);
        trig_l0_req = l0;
        trig_l1_req = l1;
        @(negedge dtc_clk);
        trig_l0_req = 1'b0;
        trig_l1_req = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            @(negedge dtc_clk);
        end
        if (busy) chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic count_not_ready(output int n);
        n = 0;
        while (!cmd_ready && n < 500) begin
            n++;
            @(negedge dtc_clk);
        end
    endtask

    initial begin
        int          n;
        logic [3:0]  bad_codes [6];
        logic [3:0]  short_codes [5];
        bad_codes   = '{4'h0, 4'h1, 4'h2, 4'hB, 4'hC, 4'hF};
        short_codes = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h8};

        // Reset state
        repeat (3) @(negedge dtc_clk);
        chk("rst_trig", 64'(dtc_trig), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_drop", 64'(trig_drop), 64'd0);
        chk("rst_err", 64'(cmd_err), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge dtc_clk);

        // STREQ from idle: one-cycle latency and busy length
        push_frame(4'h7, 32'h0, 32'h0);
        send_cmd(4'h7, 32'h0, 32'h0);
        chk("streq_pre_start", 64'(busy), 64'd0);
        @(negedge dtc_clk);
        chk("streq_start_bit", 64'(dtc_trig), 64'd1);
        wait_idle(n);
        chk("streq_busy_len", 64'(n), 64'(5 + P + G));
        repeat (2) @(negedge dtc_clk);
        chk("streq_q_empty", 64'(exp_q.size()), 64'd0);

        // WRITE: full payload, cmd_ready low across frame and guard
        push_frame(4'h9, 32'h0000_0010, 32'hDEAD_BEEF);
        send_cmd(4'h9, 32'h0000_0010, 32'hDEAD_BEEF);
        count_not_ready(n);
        chk("write_not_ready", 64'(n), 64'(69 + P + G));
        wait_idle(n);
        repeat (2) @(negedge dtc_clk);
        chk("write_q_empty", 64'(exp_q.size()), 64'd0);

        // Simultaneous L0 and L1: L0 then L1 back to back
        push_frame(4'h1, 32'h0, 32'h0);
        push_frame(4'h2, 32'h0, 32'h0);
        pulse_trig(1'b1, 1'b1);
        count_not_ready(n);
        chk("dual_not_ready", 64'(n), 64'(2 * (5 + P + G)));
        wait_idle(n);
        repeat (2) @(negedge dtc_clk);
        chk("dual_q_empty", 64'(exp_q.size()), 64'd0);

        // READ with L0 twice (one drop) and a host command waiting behind L0
        drop_cnt = 0;
        push_frame(4'hA, 32'hA5A5_0F0F, 32'h0);
        send_cmd(4'hA, 32'hA5A5_0F0F, 32'h1234_5678);
        repeat (3) @(negedge dtc_clk);
        push_frame(4'h1, 32'h0, 32'h0);
        pulse_trig(1'b1, 1'b0);
        repeat (2) @(negedge dtc_clk);
        pulse_trig(1'b1, 1'b0);
        push_frame(4'h6, 32'h0, 32'h0);
        send_cmd(4'h6, 32'h0, 32'h0);
        @(negedge dtc_clk);
        wait_idle(n);
        repeat (2) @(negedge dtc_clk);
        chk("drop_count", 64'(drop_cnt), 64'd1);
        chk("read_q_empty", 64'(exp_q.size()), 64'd0);

        // Short legal codes back to back
        foreach (short_codes[i]) begin
            push_frame(short_codes[i], 32'h0, 32'h0);
            send_cmd(short_codes[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        end
        @(negedge dtc_clk);
        wait_idle(n);
        repeat (2) @(negedge dtc_clk);
        chk("short_q_empty", 64'(exp_q.size()), 64'd0);

        // Illegal codes: one cmd_err pulse, no frame
        foreach (bad_codes[i]) begin
            err_cnt = 0;
            send_cmd(bad_codes[i], 32'h5555_AAAA, 32'h0F0F_F0F0);
            chk("err_pulse", 64'(cmd_err), 64'd1);
            repeat (4) @(negedge dtc_clk);
            chk("err_busy", 64'(busy), 64'd0);
            chk("err_count", 64'(err_cnt), 64'd1);
        end

        // Reset at bit 20 of a WRITE with L1 pending
        push_frame(4'h9, 32'hFFFF_FFFF, 32'h0);
        send_cmd(4'h9, 32'hFFFF_FFFF, 32'h0);
        trig_l1_req = 1'b1;
        @(negedge dtc_clk);
        trig_l1_req = 1'b0;
        repeat (20) @(posedge dtc_clk);
        #3;
        chk("pre_reset_line", 64'(dtc_trig), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_trig", 64'(dtc_trig), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge dtc_clk);
        #3;
        rst_n = 1'b1;
        n = 0;
        repeat (150) begin
            @(negedge dtc_clk);
            if (busy) n++;
        end
        chk("post_reset_busy", 64'(n), 64'd0);
        chk("post_reset_ready", 64'(cmd_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
